// File: rtl/hsv_core_pkg.sv
// Shared core types for the memory unit: address-stage transactions, uop metadata,
// response records, trap cause codes and load-data extraction.
package hsv_core_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
    mem_size_t   size;
    logic        sign_extend;
  } mem_data_t;

  typedef struct packed {
    mem_data_t   mem_data;
    logic [31:0] address;
    logic [1:0]  read_shift;
    logic        is_memory;
    logic        is_write;
    logic        unaligned_address;
  } read_write_t;

  typedef struct packed {
    logic [31:0] result;
    mem_data_t   mem_data;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] tval;
  } mem_resp_t;

  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Shift the addressed byte lane down to bit 0, then zero/sign extend by access size.
  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  shift,
                                              input mem_size_t   size,
                                              input logic        sext);
    logic [31:0] s;
    s = rdata >> {shift, 3'b000};
    case (size)
      MEM_BYTE: extend_load = {{24{sext & s[7]}}, s[7:0]};
      MEM_HALF: extend_load = {{16{sext & s[15]}}, s[15:0]};
      default:  extend_load = s;
    endcase
  endfunction

endpackage

// File: rtl/hsv_core_mem_response_queue.sv
// In-order FIFO of outstanding address-stage transactions; a full flag separates
// full from empty when the wrapping pointers coincide.
module hsv_core_mem_response_queue
  import hsv_core_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        flush,
  input  logic        push,
  input  read_write_t push_data,
  input  logic        pop,
  output read_write_t head,
  output logic        full,
  output logic        empty
);

  localparam int PtrW = $clog2(Depth);

  read_write_t           mem [Depth];
  logic [PtrW-1:0]       wptr;
  logic [PtrW-1:0]       rptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wptr == rptr) && !full;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk_core) begin
    if (rst_core || flush) begin
      wptr <= '0;
      rptr <= '0;
      full <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + PtrW'(1);
      if (do_pop)  rptr <= rptr + PtrW'(1);
      if (do_push && !do_pop)
        full <= ((wptr + PtrW'(1)) == rptr);
      else if (do_pop && !do_push)
        full <= 1'b0;
    end
  end

  always_ff @(posedge clk_core) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/hsv_core_mem_response.sv
// Memory response stage: matches queued transactions to dmem R/B responses, extracts
// load data, raises faults, and drops responses orphaned by a flush.
module hsv_core_mem_response
  import hsv_core_pkg::*;
#(
  parameter int QueueDepth  = 4,
  parameter int MaxInflight = 8
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        flush,
  input  read_write_t transaction,
  input  logic        response_valid_i,
  output logic        response_stall_o,
  input  logic        req_issued_i,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  input  logic        mem_bvalid,
  input  logic [1:0]  mem_bresp,
  output logic        mem_bready,
  input  logic        commit_stall,
  output logic        valid_o,
  output logic [31:0] result_o,
  output mem_data_t   mem_data_o,
  output logic        trap_o,
  output logic [3:0]  trap_cause_o,
  output logic [31:0] trap_value_o
);

  localparam int CntW = $clog2(MaxInflight + 1);

  read_write_t     head;
  logic            q_full;
  logic            q_empty;
  logic            push;
  logic            pop;
  logic            head_trap_only;
  logic            head_read;
  logic            head_write;
  logic            out_valid;
  logic            out_can_load;
  logic            discarding;
  logic            r_accept;
  logic            b_accept;
  mem_resp_t       out_q;
  mem_resp_t       out_d;
  logic [CntW-1:0] inflight_cnt;
  logic [CntW-1:0] discard_cnt;
  logic [CntW-1:0] discard_dec;
  logic [CntW-1:0] discard_nxt;
  logic [CntW:0]   inflight_sum;
  logic            unused_addr_lsb;

  hsv_core_mem_response_queue #(.Depth(QueueDepth)) u_queue (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .flush     (flush),
    .push      (push),
    .push_data (transaction),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign response_stall_o = q_full;
  assign push             = response_valid_i && !q_full && !flush;

  assign head_trap_only = !q_empty && (head.unaligned_address || !head.is_memory);
  assign head_read      = !q_empty && !head_trap_only && !head.is_write;
  assign head_write     = !q_empty && !head_trap_only && head.is_write;

  assign out_can_load = !out_valid || !commit_stall;
  assign discarding   = (discard_cnt != '0);

  assign mem_rready = discarding || (head_read && out_can_load);
  assign mem_bready = discarding || (head_write && out_can_load);
  assign r_accept   = mem_rvalid && mem_rready;
  assign b_accept   = mem_bvalid && mem_bready;

  // Trap-only heads never touch the bus, so they may retire even while discarding.
  assign pop = !flush && out_can_load &&
               (head_trap_only ||
                (!discarding && ((head_read && mem_rvalid) || (head_write && mem_bvalid))));

  always_comb begin
    out_d          = '0;
    out_d.mem_data = head.mem_data;
    out_d.tval     = {head.address[31:2], head.read_shift};
    if (head.unaligned_address) begin
      out_d.trap  = 1'b1;
      out_d.cause = head.is_write ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
    end else if (!head.is_memory) begin
      out_d.trap  = 1'b1;
      out_d.cause = head.is_write ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
    end else if (head.is_write) begin
      if (mem_bresp != AXI_RESP_OKAY) begin
        out_d.trap  = 1'b1;
        out_d.cause = EXC_STORE_FAULT;
      end
    end else if (mem_rresp != AXI_RESP_OKAY) begin
      out_d.trap  = 1'b1;
      out_d.cause = EXC_LOAD_FAULT;
    end else begin
      out_d.result = extend_load(mem_rdata, head.read_shift,
                                 head.mem_data.size, head.mem_data.sign_extend);
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_can_load) begin
      out_valid <= pop;
      if (pop) out_q <= out_d;
    end
  end

  assign valid_o      = out_valid;
  assign result_o     = out_q.result;
  assign mem_data_o   = out_q.mem_data;
  assign trap_o       = out_valid && out_q.trap;
  assign trap_cause_o = out_q.cause;
  assign trap_value_o = out_q.tval;

  always_comb begin
    inflight_sum = {1'b0, inflight_cnt} + (CntW+1)'(req_issued_i)
                   - (CntW+1)'(r_accept) - (CntW+1)'(b_accept);
    discard_dec  = CntW'(r_accept) + CntW'(b_accept);
    discard_nxt  = (discard_cnt > discard_dec) ? (discard_cnt - discard_dec) : '0;
  end

  // On flush every response still owed by the bus belongs to a squashed transaction.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      inflight_cnt <= '0;
      discard_cnt  <= '0;
    end else begin
      inflight_cnt <= inflight_sum[CntW-1:0];
      if (flush)
        discard_cnt <= inflight_sum[CntW-1:0];
      else if (discarding)
        discard_cnt <= discard_nxt;
    end
  end

  always_ff @(posedge clk_core) begin
    if (!rst_core) assert (inflight_sum <= (CntW+1)'(MaxInflight));
  end

  assign unused_addr_lsb = ^head.address[1:0];

endmodule

// File: tb/tb_hsv_core_mem_response.sv
// Directed bench for the memory response stage: table of single transactions plus
// hand-written sequences for backpressure, flush discard, counter balance and reset.
module tb_hsv_core_mem_response;
  import hsv_core_pkg::*;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        flush;
  read_write_t transaction;
  logic        response_valid_i;
  logic        response_stall_o;
  logic        req_issued_i;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        mem_bvalid;
  logic [1:0]  mem_bresp;
  logic        mem_bready;
  logic        commit_stall;
  logic        valid_o;
  logic [31:0] result_o;
  mem_data_t   mem_data_o;
  logic        trap_o;
  logic [3:0]  trap_cause_o;
  logic [31:0] trap_value_o;

  int checks = 0;
  int errors = 0;

  hsv_core_mem_response #(.QueueDepth(4), .MaxInflight(8)) dut (
    .clk_core         (clk_core),
    .rst_core         (rst_core),
    .flush            (flush),
    .transaction      (transaction),
    .response_valid_i (response_valid_i),
    .response_stall_o (response_stall_o),
    .req_issued_i     (req_issued_i),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .mem_rresp        (mem_rresp),
    .mem_rready       (mem_rready),
    .mem_bvalid       (mem_bvalid),
    .mem_bresp        (mem_bresp),
    .mem_bready       (mem_bready),
    .commit_stall     (commit_stall),
    .valid_o          (valid_o),
    .result_o         (result_o),
    .mem_data_o       (mem_data_o),
    .trap_o           (trap_o),
    .trap_cause_o     (trap_cause_o),
    .trap_value_o     (trap_value_o)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    mem_size_t   size;
    logic        sext;
    logic [1:0]  shift;
    logic        is_write;
    logic        is_mem;
    logic        unal;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_result;
    logic        exp_trap;
    logic [3:0]  exp_cause;
    logic [31:0] exp_tval;
  } vec_t;

  vec_t vecs [12];

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic read_write_t mk_txn(input mem_size_t size, input logic sext,
                                         input logic [1:0] shift, input logic wr,
                                         input logic is_mem, input logic unal,
                                         input logic [31:0] addr, input logic [4:0] rd);
    read_write_t t;
    t = '0;
    t.mem_data.rd          = rd;
    t.mem_data.pc          = 32'h0000_1000 + {25'd0, rd, 2'b00};
    t.mem_data.size        = size;
    t.mem_data.sign_extend = sext;
    t.address              = addr;
    t.read_shift           = shift;
    t.is_memory            = is_mem;
    t.is_write             = wr;
    t.unaligned_address    = unal;
    return t;
  endfunction

  task automatic push_word_load(input logic [4:0] rd);
    transaction      = mk_txn(MEM_WORD, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, rd);
    response_valid_i = 1'b1;
    req_issued_i     = 1'b1;
    tick();
    response_valid_i = 1'b0;
    req_issued_i     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{MEM_BYTE, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h80FF_0000, 2'b00,
                 32'hFFFF_FF80, 1'b0, 4'd0, 32'h0};
    vecs[1]  = '{MEM_BYTE, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h80FF_0000, 2'b00,
                 32'h0000_0080, 1'b0, 4'd0, 32'h0};
    vecs[2]  = '{MEM_HALF, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0,         2'b00,
                 32'h0,         1'b1, 4'd4, 32'h0000_0101};
    vecs[3]  = '{MEM_WORD, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b10,
                 32'h0,         1'b1, 4'd7, 32'h0000_0040};
    vecs[4]  = '{MEM_HALF, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h8001_1234, 2'b00,
                 32'hFFFF_8001, 1'b0, 4'd0, 32'h0};
    vecs[5]  = '{MEM_HALF, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h8001_1234, 2'b00,
                 32'h0000_8001, 1'b0, 4'd0, 32'h0};
    vecs[6]  = '{MEM_WORD, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 2'b00,
                 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0};
    vecs[7]  = '{MEM_WORD, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678, 2'b10,
                 32'h0,         1'b1, 4'd5, 32'h0000_0080};
    vecs[8]  = '{MEM_WORD, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0,         2'b00,
                 32'h0,         1'b1, 4'd5, 32'h0000_0300};
    vecs[9]  = '{MEM_WORD, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0,         2'b00,
                 32'h0,         1'b0, 4'd0, 32'h0};
    vecs[10] = '{MEM_WORD, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 32'h0,         2'b00,
                 32'h0,         1'b1, 4'd6, 32'h0000_0102};
    vecs[11] = '{MEM_BYTE, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_7F00, 2'b00,
                 32'h0000_007F, 1'b0, 4'd0, 32'h0};

    rst_core = 1'b1; flush = 1'b0; transaction = '0; response_valid_i = 1'b0;
    req_issued_i = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
    mem_bvalid = 1'b0; mem_bresp = '0; commit_stall = 1'b0;
    tick();
    tick();
    rst_core = 1'b0;
    #1;
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_trap", 32'(trap_o), 32'd0);
    chk("reset_rready", 32'(mem_rready), 32'd0);
    chk("reset_bready", 32'(mem_bready), 32'd0);
    chk("reset_stall", 32'(response_stall_o), 32'd0);

    // Table of single transactions
    for (int i = 0; i < 12; i++) begin
      logic bus;
      bus = vecs[i].is_mem && !vecs[i].unal;
      transaction = mk_txn(vecs[i].size, vecs[i].sext, vecs[i].shift, vecs[i].is_write,
                           vecs[i].is_mem, vecs[i].unal, vecs[i].addr, 5'(i + 1));
      response_valid_i = 1'b1;
      req_issued_i     = bus;
      tick();
      response_valid_i = 1'b0;
      req_issued_i     = 1'b0;
      if (bus && vecs[i].is_write) begin
        mem_bvalid = 1'b1; mem_bresp = vecs[i].resp;
      end else if (bus) begin
        mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata; mem_rresp = vecs[i].resp;
      end
      #1;
      chk($sformatf("v%0d_rready", i), 32'(mem_rready), 32'(bus && !vecs[i].is_write));
      chk($sformatf("v%0d_bready", i), 32'(mem_bready), 32'(bus && vecs[i].is_write));
      tick();
      mem_rvalid = 1'b0; mem_bvalid = 1'b0; mem_rresp = '0; mem_bresp = '0;
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'd1);
      chk($sformatf("v%0d_result", i), result_o, vecs[i].exp_result);
      chk($sformatf("v%0d_trap", i), 32'(trap_o), 32'(vecs[i].exp_trap));
      chk($sformatf("v%0d_rd", i), 32'(mem_data_o.rd), 32'(i + 1));
      if (vecs[i].exp_trap) begin
        chk($sformatf("v%0d_cause", i), 32'(trap_cause_o), 32'(vecs[i].exp_cause));
        chk($sformatf("v%0d_tval", i), trap_value_o, vecs[i].exp_tval);
      end
      tick();
      chk($sformatf("v%0d_drain", i), 32'(valid_o), 32'd0);
    end

    // Four loads queued against a stalled commit
    commit_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_word_load(5'(k));
      if (k == 2) chk("stall_after3", 32'(response_stall_o), 32'd0);
    end
    chk("stall_after4", 32'(response_stall_o), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
    #1;
    chk("bp_rready0", 32'(mem_rready), 32'd1);
    tick();
    chk("bp_valid0", 32'(valid_o), 32'd1);
    chk("bp_res0", result_o, 32'h0000_0011);
    chk("bp_stall_drop", 32'(response_stall_o), 32'd0);
    mem_rdata = 32'h0000_0022;
    #1;
    chk("bp_rready_held", 32'(mem_rready), 32'd0);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("bp_hold_valid", 32'(valid_o), 32'd1);
      chk("bp_hold_res", result_o, 32'h0000_0011);
      chk("bp_hold_rd", 32'(mem_data_o.rd), 32'd0);
    end
    commit_stall = 1'b0;
    #1;
    chk("bp_rready_rel", 32'(mem_rready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("bp_seq_valid", 32'(valid_o), 32'd1);
      chk("bp_seq_res", result_o, 32'h11 * (k + 1));
      chk("bp_seq_rd", 32'(mem_data_o.rd), 32'(k));
      mem_rdata = 32'h11 * (k + 2);
    end
    mem_rvalid = 1'b0;
    tick();
    chk("bp_end_valid", 32'(valid_o), 32'd0);

    // Flush with three responses outstanding
    for (int k = 0; k < 3; k++) push_word_load(5'(k + 8));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_discard3", 32'(dut.discard_cnt), 32'd3);
    chk("fl_valid", 32'(valid_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0000 + 32'(k);
      #1;
      chk("fl_rready", 32'(mem_rready), 32'd1);
      tick();
      chk("fl_dropped", 32'(valid_o), 32'd0);
    end
    mem_rvalid = 1'b0;
    chk("fl_discard0", 32'(dut.discard_cnt), 32'd0);
    chk("fl_inflight0", 32'(dut.inflight_cnt), 32'd0);
    push_word_load(5'd20);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("fl_next_valid", 32'(valid_o), 32'd1);
    chk("fl_next_res", result_o, 32'hCAFE_F00D);
    tick();

    // Issue and response in the same cycle keep the in-flight count balanced
    push_word_load(5'd1);
    for (int c = 0; c < 20; c++) begin
      transaction      = mk_txn(MEM_WORD, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 5'd1);
      response_valid_i = 1'b1;
      req_issued_i     = 1'b1;
      mem_rvalid       = 1'b1;
      mem_rdata        = 32'h0000_1000 + 32'(c);
      tick();
      chk("bal_inflight", 32'(dut.inflight_cnt), 32'd1);
      chk("bal_res", result_o, 32'h0000_1000 + 32'(c));
    end
    response_valid_i = 1'b0; req_issued_i = 1'b0;
    mem_rdata = 32'h0000_0099;
    tick();
    mem_rvalid = 1'b0;
    chk("bal_last_res", result_o, 32'h0000_0099);
    chk("bal_inflight0", 32'(dut.inflight_cnt), 32'd0);
    tick();

    // Reset in the middle of a discard window
    push_word_load(5'd2);
    push_word_load(5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rst_pre_discard", 32'(dut.discard_cnt), 32'd2);
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
    chk("rst_discard", 32'(dut.discard_cnt), 32'd0);
    chk("rst_inflight", 32'(dut.inflight_cnt), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_rready", 32'(mem_rready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
